param_alu: RTL

- Parametrised successor to the team's single-bit-opcode 8-bit simple ALU.
- Generalises the data width and widens the opcode to 3 bits.
- Adds an iterative multi-cycle multiply, a busy flag, and an error/abort indication.
- Sits between the ALU test driver and the ALU checker using the same opcode_valid/data serial-operand protocol.

---
 rtl/param_alu.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/param_alu.sv
// param_alu: parametrised serial-operand ALU.
//   An operation takes two consecutive opcode_valid cycles. The first carries
//   operand A and the opcode, the second carries operand B. ADD/SUB/AND/OR/XOR
//   finish in one execute cycle. MUL is an iterative shift-add that takes
//   DATA_WIDTH cycles. Illegal opcodes complete with done and error together.
//   If the B cycle is missing, the operation is aborted with an error pulse.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   opcode_valid high for the A cycle and then the B cycle of an operation
//   opcode       operation select, sampled in the A cycle only
//   data         operand A, then operand B
//   result       registered result, held until the next done
//   overflow     carry / borrow / high-product flag, held with result
//   done         one-cycle completion pulse
//   busy         high from A capture until the done cycle
//   error        one-cycle pulse on abort or illegal opcode
module param_alu #(
  parameter int DATA_WIDTH = 8,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  done,
  output logic                  busy,
  output logic                  error
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_B   = 2'd1,
    ST_EXEC     = 2'd2,
    ST_MUL_ITER = 2'd3
  } state_t;

  state_t                    state_r, next_state_s;
  logic [DATA_WIDTH-1:0]     a_r, b_r;
  logic [2:0]                op_r;
  logic [2*DATA_WIDTH-1:0]   prod_r, mcand_r, mul_addend_s, prod_sum_s;
  logic [DATA_WIDTH-1:0]     mplier_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      mul_sel_s, last_iter_s;
  logic [DATA_WIDTH:0]       add_full_s, sub_full_s;
  logic [DATA_WIDTH-1:0]     exec_result_s;
  logic                      exec_ovf_s, exec_illegal_s;
  logic [DATA_WIDTH-1:0]     result_r, result_nxt_s;
  logic                      overflow_r, overflow_nxt_s;
  logic                      done_r, done_nxt_s;
  logic                      busy_r, busy_nxt_s;
  logic                      error_r, error_nxt_s;

  assign mul_sel_s   = MUL_EN && (op_r == OP_MUL);
  assign last_iter_s = (state_r == ST_MUL_ITER) && (cnt_r == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (opcode_valid) next_state_s = ST_LOAD_B;
        else              next_state_s = ST_IDLE;
      end
      ST_LOAD_B: begin
        if (!opcode_valid) next_state_s = ST_IDLE;
        else if (mul_sel_s) next_state_s = ST_MUL_ITER;
        else                next_state_s = ST_EXEC;
      end
      ST_EXEC: next_state_s = ST_IDLE;
      ST_MUL_ITER: begin
        if (last_iter_s) next_state_s = ST_IDLE;
        else             next_state_s = ST_MUL_ITER;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Single-cycle operations. MUL only reaches EXEC when MUL_EN=0, so it is illegal here.
  always_comb begin
    add_full_s     = {1'b0, a_r} + {1'b0, b_r};
    sub_full_s     = {1'b0, a_r} - {1'b0, b_r};
    exec_result_s  = {DATA_WIDTH{1'b0}};
    exec_ovf_s     = 1'b0;
    exec_illegal_s = 1'b0;
    case (op_r)
      OP_ADD: begin
        exec_result_s = add_full_s[DATA_WIDTH-1:0];
        exec_ovf_s    = add_full_s[DATA_WIDTH];
      end
      OP_SUB: begin
        // The extra bit of the widened difference is the borrow, i.e. A < B.
        exec_result_s = sub_full_s[DATA_WIDTH-1:0];
        exec_ovf_s    = sub_full_s[DATA_WIDTH];
      end
      OP_AND:  exec_result_s = a_r & b_r;
      OP_OR:   exec_result_s = a_r | b_r;
      OP_XOR:  exec_result_s = a_r ^ b_r;
      default: exec_illegal_s = 1'b1;
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[0]) mul_addend_s = mcand_r;
    else             mul_addend_s = {(2*DATA_WIDTH){1'b0}};
    prod_sum_s = prod_r + mul_addend_s;
  end

  // Next values of the registered outputs.
  always_comb begin
    result_nxt_s   = result_r;
    overflow_nxt_s = overflow_r;
    done_nxt_s     = 1'b0;
    busy_nxt_s     = busy_r;
    error_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (opcode_valid) busy_nxt_s = 1'b1;
        else              busy_nxt_s = busy_r;
      end
      ST_LOAD_B: begin
        if (!opcode_valid) begin
          error_nxt_s = 1'b1;
          busy_nxt_s  = 1'b0;
        end else begin
          busy_nxt_s  = busy_r;
        end
      end
      ST_EXEC: begin
        result_nxt_s   = exec_result_s;
        overflow_nxt_s = exec_ovf_s;
        done_nxt_s     = 1'b1;
        busy_nxt_s     = 1'b0;
        error_nxt_s    = exec_illegal_s;
      end
      ST_MUL_ITER: begin
        if (last_iter_s) begin
          result_nxt_s   = prod_sum_s[DATA_WIDTH-1:0];
          overflow_nxt_s = |prod_sum_s[2*DATA_WIDTH-1:DATA_WIDTH];
          done_nxt_s     = 1'b1;
          busy_nxt_s     = 1'b0;
        end else begin
          busy_nxt_s     = busy_r;
        end
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand capture and multiplier datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= {DATA_WIDTH{1'b0}};
      b_r      <= {DATA_WIDTH{1'b0}};
      op_r     <= 3'd0;
      prod_r   <= {(2*DATA_WIDTH){1'b0}};
      mcand_r  <= {(2*DATA_WIDTH){1'b0}};
      mplier_r <= {DATA_WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (state_r == ST_IDLE && opcode_valid) begin
        a_r  <= data;
        op_r <= opcode;
      end
      if (state_r == ST_LOAD_B && opcode_valid) begin
        b_r      <= data;
        mcand_r  <= {{DATA_WIDTH{1'b0}}, a_r};
        mplier_r <= data;
        prod_r   <= {(2*DATA_WIDTH){1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
      end
      if (state_r == ST_MUL_ITER) begin
        prod_r   <= prod_sum_s;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r   <= {DATA_WIDTH{1'b0}};
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      result_r   <= result_nxt_s;
      overflow_r <= overflow_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
      error_r    <= error_nxt_s;
    end
  end

  assign result   = result_r;
  assign overflow = overflow_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign error    = error_r;

endmodule
